alu_req_driver: RTL

- Initiator-side front end for the team's registered 4-op ALU (add, sub, incr, decr).
- Accepts operation requests on a valid/ready interface, drives the ALU's OPCODE/OP1/OP2 ports from registers, and waits out the ALU's one-cycle registered latency.
- Captures RESULT/CARRY/ZERO and returns them on a valid/ready response interface.
- Sits between the command source (sequencer/testbench) and the ALU; one transaction in flight at a time.

---
 rtl/alu_req_driver.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/alu_req_driver.sv
// alu_req_driver: initiator-side front end for the registered 4-op ALU.
// Accepts one request at a time, drives the ALU operand registers, waits out
// the ALU's one-cycle latency, then returns the captured flags on a
// valid/ready response interface.
// Optional build macro ALU_CHECK_EN adds a shadow checker that raises a
// sticky chk_fail when the ALU outputs disagree with the expected value.
module alu_req_driver #(
   parameter int OPCODE_WIDTH = 2,
   parameter int DATA_WIDTH   = 3,
   parameter int CNT_WIDTH    = 8
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [OPCODE_WIDTH:0]   req_opcode,
   input  logic [DATA_WIDTH:0]     req_op1,
   input  logic [DATA_WIDTH:0]     req_op2,
   output logic [OPCODE_WIDTH:0]   alu_opcode,
   output logic [DATA_WIDTH:0]     alu_op1,
   output logic [DATA_WIDTH:0]     alu_op2,
   input  logic [DATA_WIDTH:0]     alu_result,
   input  logic                    alu_carry,
   input  logic                    alu_zero,
   output logic                    resp_valid,
   input  logic                    resp_ready,
   output logic [DATA_WIDTH:0]     resp_result,
   output logic                    resp_carry,
   output logic                    resp_zero,
   output logic                    resp_err,
   output logic [CNT_WIDTH-1:0]    txn_count,
   output logic                    chk_fail
);

   typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;

   // Highest legal opcode: 0=add, 1=sub, 2=incr, 3=decr.
   localparam logic [OPCODE_WIDTH:0] OP_LAST = (OPCODE_WIDTH+1)'(3);

   state_t                  state_q, state_d;
   logic [OPCODE_WIDTH:0]   alu_opcode_q, alu_opcode_d;
   logic [DATA_WIDTH:0]     alu_op1_q, alu_op1_d;
   logic [DATA_WIDTH:0]     alu_op2_q, alu_op2_d;
   logic [DATA_WIDTH:0]     resp_result_q, resp_result_d;
   logic                    resp_carry_q, resp_carry_d;
   logic                    resp_zero_q, resp_zero_d;
   logic                    resp_err_q, resp_err_d;
   logic [CNT_WIDTH-1:0]    txn_count_q, txn_count_d;

   // Next-state and register-load decisions for the transaction FSM.
   always_comb begin
      state_d       = state_q;
      alu_opcode_d  = alu_opcode_q;
      alu_op1_d     = alu_op1_q;
      alu_op2_d     = alu_op2_q;
      resp_result_d = resp_result_q;
      resp_carry_d  = resp_carry_q;
      resp_zero_d   = resp_zero_q;
      resp_err_d    = resp_err_q;
      txn_count_d   = txn_count_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (req_opcode <= OP_LAST) begin
                  alu_opcode_d = req_opcode;
                  alu_op1_d    = req_op1;
                  alu_op2_d    = req_op2;
                  state_d      = EXEC;
               end else begin
                  // Illegal opcode never reaches the ALU; answer immediately.
                  resp_result_d = '0;
                  resp_carry_d  = 1'b0;
                  resp_zero_d   = 1'b0;
                  resp_err_d    = 1'b1;
                  state_d       = RESP;
               end
            end
         end
         EXEC: state_d = CAPT;
         CAPT: begin
            resp_result_d = alu_result;
            resp_carry_d  = alu_carry;
            resp_zero_d   = alu_zero;
            resp_err_d    = 1'b0;
            state_d       = RESP;
         end
         RESP: begin
            if (resp_ready) begin
               txn_count_d = txn_count_q + 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any transaction silently.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q       <= IDLE;
         alu_opcode_q  <= '0;
         alu_op1_q     <= '0;
         alu_op2_q     <= '0;
         resp_result_q <= '0;
         resp_carry_q  <= 1'b0;
         resp_zero_q   <= 1'b0;
         resp_err_q    <= 1'b0;
         txn_count_q   <= '0;
      end else begin
         state_q       <= state_d;
         alu_opcode_q  <= alu_opcode_d;
         alu_op1_q     <= alu_op1_d;
         alu_op2_q     <= alu_op2_d;
         resp_result_q <= resp_result_d;
         resp_carry_q  <= resp_carry_d;
         resp_zero_q   <= resp_zero_d;
         resp_err_q    <= resp_err_d;
         txn_count_q   <= txn_count_d;
      end
   end

   assign req_ready   = (state_q == IDLE);
   assign resp_valid  = (state_q == RESP);
   assign alu_opcode  = alu_opcode_q;
   assign alu_op1     = alu_op1_q;
   assign alu_op2     = alu_op2_q;
   assign resp_result = resp_result_q;
   assign resp_carry  = resp_carry_q;
   assign resp_zero   = resp_zero_q;
   assign resp_err    = resp_err_q;
   assign txn_count   = txn_count_q;

`ifdef ALU_CHECK_EN
   // Expected ALU output, one bit wider than the data so the MSB is carry/borrow.
   function automatic logic [DATA_WIDTH+1:0] alu_expect(
      input logic [OPCODE_WIDTH:0] op,
      input logic [DATA_WIDTH:0]   a,
      input logic [DATA_WIDTH:0]   b
   );
      logic [DATA_WIDTH+1:0] ax, bx, one;
      ax  = {1'b0, a};
      bx  = {1'b0, b};
      one = (DATA_WIDTH+2)'(1);
      case (op)
         (OPCODE_WIDTH+1)'(0): alu_expect = ax + bx;
         (OPCODE_WIDTH+1)'(1): alu_expect = ax - bx;
         (OPCODE_WIDTH+1)'(2): alu_expect = ax + one;
         (OPCODE_WIDTH+1)'(3): alu_expect = ax - one;
         default:              alu_expect = '0;
      endcase
   endfunction

   logic                  chk_fail_q, chk_fail_d;
   logic [DATA_WIDTH+1:0] exp_full;

   // Compare the sampled ALU outputs against the shadow computation in CAPT.
   always_comb begin
      chk_fail_d = chk_fail_q;
      exp_full   = alu_expect(alu_opcode_q, alu_op1_q, alu_op2_q);
      if (state_q == CAPT) begin
         if ((alu_result != exp_full[DATA_WIDTH:0]) ||
             (alu_carry  != exp_full[DATA_WIDTH+1]) ||
             (alu_zero   != (exp_full == '0)))
            chk_fail_d = 1'b1;
      end
   end

   // Sticky failure flag, cleared only by reset.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) chk_fail_q <= 1'b0;
      else       chk_fail_q <= chk_fail_d;
   end

   assign chk_fail = chk_fail_q;
`else
   assign chk_fail = 1'b0;
`endif

endmodule
